// File: rtl/seq_subtractor_slice_if.sv
// Operand/result handshake bundle for the sliced subtractor.
// master = producer/consumer side, slave = subtractor side.
interface seq_subtractor_slice_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zf, sf, of
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zf, sf, of
  );
endinterface

// File: rtl/seq_subtractor_slice.sv
// Multi-cycle a - b (as a + ~b + 1), one SLICE-bit ripple segment per clock,
// with Y86-style borrow/zero/sign/overflow flags and valid/ready on both sides.
module seq_subtractor_slice #(
  parameter int WIDTH = 64,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_subtractor_slice_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bn_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             zf_r;
  logic             sf_r;
  logic             of_r;
  logic             in_ready_r;
  logic             out_valid_r;

  int               base_s;
  logic [SLICE-1:0] sum_s;
  logic             carry_out_s;
  logic [WIDTH-1:0] next_diff_s;

  function automatic logic [SLICE:0] slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             cin
  );
    slice_add = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
  endfunction

  // Current slice sum and the diff word as it will look once this slice is written.
  always_comb begin
    base_s                        = int'(idx_r) * SLICE;
    {carry_out_s, sum_s}          = slice_add(a_r[base_s +: SLICE], bn_r[base_s +: SLICE], carry_r);
    next_diff_s                   = diff_r;
    next_diff_s[base_s +: SLICE]  = sum_s;
  end

  // Handshake FSM, slice sequencing and registered result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      bn_r        <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      diff_r      <= {WIDTH{1'b0}};
      borrow_r    <= 1'b0;
      zf_r        <= 1'b0;
      sf_r        <= 1'b0;
      of_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            bn_r       <= ~bus.b;
            carry_r    <= 1'b1;
            idx_r      <= {IDXW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          diff_r  <= next_diff_s;
          carry_r <= carry_out_s;
          if (idx_r == IDXW'(NSLICE - 1)) begin
            // Flags come from the completed word, so use next_diff_s, not diff_r.
            borrow_r    <= ~carry_out_s;
            zf_r        <= (next_diff_s == {WIDTH{1'b0}});
            sf_r        <= next_diff_s[WIDTH-1];
            of_r        <= (a_r[WIDTH-1] == bn_r[WIDTH-1]) && (next_diff_s[WIDTH-1] != a_r[WIDTH-1]);
            idx_r       <= {IDXW{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.borrow    = borrow_r;
  assign bus.zf        = zf_r;
  assign bus.sf        = sf_r;
  assign bus.of        = of_r;
endmodule

// File: tb/tb_seq_subtractor_slice.sv
// Bench for seq_subtractor_slice: fixed vector table, randomized operands against
// an arithmetic reference, plus backpressure and mid-operation reset sequences.
module tb_seq_subtractor_slice;
  localparam int WIDTH   = 64;
  localparam int LATENCY = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_subtractor_slice_if #(.WIDTH(WIDTH)) bus ();
  seq_subtractor_slice #(.WIDTH(WIDTH), .SLICE(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] diff;
    logic        borrow;
    logic        zf;
    logic        sf;
    logic        of;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the whole operands.
  function automatic vec_t model(input logic [63:0] a, input logic [63:0] b);
    vec_t v;
    logic signed [64:0] true_diff;
    v.a       = a;
    v.b       = b;
    v.diff    = a - b;
    v.borrow  = (a < b);
    v.zf      = (v.diff == 64'd0);
    v.sf      = v.diff[63];
    true_diff = $signed({a[63], a}) - $signed({b[63], b});
    v.of      = (true_diff != $signed({v.diff[63], v.diff}));
    return v;
  endfunction

  // Called just after a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from accept to out_valid; optionally scrambles inputs meanwhile.
  task automatic wait_result(input bit scramble, output int cyc);
    int ready_bad;
    cyc       = 0;
    ready_bad = 0;
    while (!bus.out_valid && cyc < 40) begin
      if (bus.in_ready !== 1'b0) ready_bad++;
      if (scramble) begin
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("busy_in_ready_low", 64'(ready_bad), 64'd0);
  endtask

  task automatic check_out(input string name, input vec_t v);
    chk({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_diff"},      bus.diff,           v.diff);
    chk({name, "_borrow"},    64'(bus.borrow),    64'(v.borrow));
    chk({name, "_zf"},        64'(bus.zf),        64'(v.zf));
    chk({name, "_sf"},        64'(bus.sf),        64'(v.sf));
    chk({name, "_of"},        64'(bus.of),        64'(v.of));
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("consume_out_valid", 64'(bus.out_valid), 64'd0);
    chk("consume_in_ready",  64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   seen;
    vec_t v;
    vec_t v2;

    vecs[0] = '{64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 64'd0;
    bus.b         = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_diff",      bus.diff,           64'd0);
    chk("rst_flags",     64'({bus.borrow, bus.zf, bus.sf, bus.of}), 64'd0);

    // out_ready outside DONE must not produce anything.
    bus.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    bus.out_ready = 1'b0;
    chk("idle_out_ready_ignored", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(i[0], cyc);
      chk($sformatf("vec%0d_latency", i), 64'(cyc), 64'(LATENCY));
      check_out($sformatf("vec%0d", i), vecs[i]);
      consume();
    end

    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0:       v = model({$urandom, $urandom}, {$urandom, $urandom});
        1:       v = model({1'b1, 63'($urandom)}, {$urandom, $urandom});
        2:       v = model(64'($urandom), 64'($urandom));
        default: begin
          v.a = {$urandom, $urandom};
          v = model(v.a, v.a ^ 64'(1 << $urandom_range(0, 31)));
        end
      endcase
      start_op(v.a, v.b);
      wait_result(1'b1, cyc);
      chk($sformatf("rnd%0d_latency", i), 64'(cyc), 64'(LATENCY));
      check_out($sformatf("rnd%0d", i), v);
      consume();
    end

    // Backpressure with in_valid held high through DONE and across the consume edge.
    v  = model(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF);
    v2 = model(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020);
    start_op(v.a, v.b);
    wait_result(1'b0, cyc);
    chk("bp_latency", 64'(cyc), 64'(LATENCY));
    bus.a        = v2.a;
    bus.b        = v2.b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp%0d_diff", k),      bus.diff,           v.diff);
      chk($sformatf("bp%0d_in_ready", k),  64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_consume_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_consume_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_next_accept", 64'(bus.in_ready), 64'd0);
    wait_result(1'b0, cyc);
    chk("bp_next_latency", 64'(cyc), 64'(LATENCY));
    check_out("bp_next", v2);
    consume();

    // Reset 8 cycles into BUSY aborts the operation.
    start_op(64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111);
    repeat (7) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_diff",      bus.diff,           64'd0);
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    v = model(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001);
    start_op(v.a, v.b);
    wait_result(1'b1, cyc);
    chk("post_abort_latency", 64'(cyc), 64'(LATENCY));
    check_out("post_abort", v);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
